nn_load_sequencer: RTL

NN_LOAD_SEQUENCER -- requirements
Module: nn_load_sequencer

---
 rtl/nn_load_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/nn_load_sequencer.sv
// Streams input-state and neuron-parameter bytes into a neural-network block, strobes commits
// and captures its result. Optional stall watchdog enabled by defining NN_SEQ_TIMEOUT_EN.
module nn_load_sequencer #(
   parameter int N_INPUTS          = 4,
   parameter int N_NEURONS         = 4,
   parameter int PARAMS_PER_NEURON = 6,
   parameter int RESULT_WAIT       = 2,
   parameter int TIMEOUT           = 64
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic [7:0] nn_data,
   output logic       nn_changes,
   input  logic [7:0] nn_result,
   output logic       busy,
   output logic [7:0] result,
   output logic       result_valid,
   output logic       err
);

   localparam int W_BYTES   = N_NEURONS * PARAMS_PER_NEURON;
   localparam int MAX_BYTES = (N_INPUTS > W_BYTES) ? N_INPUTS : W_BYTES;
   localparam int CNT_W     = $clog2(MAX_BYTES + 1);
   localparam int WAIT_W    = (RESULT_WAIT > 1) ? $clog2(RESULT_WAIT) : 1;

   localparam logic [CNT_W-1:0]  LAST_X    = CNT_W'(N_INPUTS - 1);
   localparam logic [CNT_W-1:0]  LAST_W    = CNT_W'(W_BYTES - 1);
   localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(RESULT_WAIT - 1);

   typedef enum logic [2:0] {
      IDLE, LOAD_X, COMMIT_X, GAP, LOAD_W, COMMIT_W, WAIT_RES, CAPTURE
   } state_t;

   state_t             state, next_state;
   logic [CNT_W-1:0]   byte_cnt;
   logic [WAIT_W-1:0]  wait_cnt;
   logic               accept;
   logic               loading;

   // in_ready is registered and high exactly in the load states, so it doubles as the handshake.
   assign accept  = in_valid && in_ready;
   assign loading = (state == LOAD_X) || (state == LOAD_W);

`ifdef NN_SEQ_TIMEOUT_EN
   localparam int STALL_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [STALL_W-1:0] LAST_STALL = STALL_W'(TIMEOUT - 1);

   logic [STALL_W-1:0] stall_cnt;
   logic               timeout_hit;

   assign timeout_hit = loading && !accept && (stall_cnt == LAST_STALL);
`else
   localparam int unused_timeout = TIMEOUT;
`endif

   // NOTE: next_state gets its default before the case so every path assigns it and no latch is inferred.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:     if (start) next_state = LOAD_X;
         LOAD_X:   if (accept && byte_cnt == LAST_X) next_state = COMMIT_X;
         COMMIT_X: next_state = GAP;
         GAP:      next_state = LOAD_W;
         LOAD_W:   if (accept && byte_cnt == LAST_W) next_state = COMMIT_W;
         COMMIT_W: next_state = WAIT_RES;
         WAIT_RES: if (wait_cnt == LAST_WAIT) next_state = CAPTURE;
         CAPTURE:  next_state = IDLE;
         default:  next_state = IDLE;
      endcase
`ifdef NN_SEQ_TIMEOUT_EN
      if (timeout_hit) next_state = IDLE;
`endif
   end

   // NOTE: all state and outputs update with non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         byte_cnt     <= '0;
         wait_cnt     <= '0;
         in_ready     <= 1'b0;
         nn_data      <= 8'h00;
         nn_changes   <= 1'b0;
         busy         <= 1'b0;
         result       <= 8'h00;
         result_valid <= 1'b0;
      end else begin
         state        <= next_state;
         in_ready     <= (next_state == LOAD_X) || (next_state == LOAD_W);
         nn_changes   <= (next_state == COMMIT_X) || (next_state == COMMIT_W);
         busy         <= (next_state != IDLE);
         result_valid <= (state == CAPTURE);

         if (accept) nn_data <= in_data;
         if (state == CAPTURE) result <= nn_result;

         if (state == IDLE || state == GAP) byte_cnt <= '0;
         else if (accept)                   byte_cnt <= byte_cnt + CNT_W'(1);

         if (state == WAIT_RES) wait_cnt <= wait_cnt + WAIT_W'(1);
         else                   wait_cnt <= '0;
      end
   end

`ifdef NN_SEQ_TIMEOUT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt <= '0;
         err       <= 1'b0;
      end else begin
         if (timeout_hit || !loading || accept) stall_cnt <= '0;
         else                                   stall_cnt <= stall_cnt + STALL_W'(1);

         if (timeout_hit)                 err <= 1'b1;
         else if (state == IDLE && start) err <= 1'b0;
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule
